// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and subordinate FSM state type for the ahb_s_mem slice.
package ahb_pkg;

  localparam int BYTE_LANES = 4;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } ahb_s_state_e;

  // Little-endian byte-lane enables for an aligned transfer.
  function automatic logic [BYTE_LANES-1:0] lane_mask(input logic [1:0] lo,
                                                      input logic [2:0] size);
    case (size)
      HSIZE_BYTE: lane_mask = 4'b0001 << lo;
      HSIZE_HALF: lane_mask = lo[1] ? 4'b1100 : 4'b0011;
      default:    lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_s_sram.sv
// Word-organised storage: byte-enable synchronous write, asynchronous read, no reset.
module ahb_s_sram
  import ahb_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int AW        = 8,
  parameter int DW        = 32
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [BYTE_LANES-1:0] i_be,
  input  logic [AW-1:0]         i_addr,
  input  logic [DW-1:0]         i_wdata,
  output logic [DW-1:0]         o_rdata
);

  logic [DW-1:0] r_mem [MEM_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int unsigned b = 0; b < BYTE_LANES; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_s_mem.sv
// AHB-Lite subordinate memory: pipelined address/data phases, programmable wait
// states, two-cycle ERROR for misaligned, oversized or out-of-range transfers.
module ahb_s_mem
  import ahb_pkg::*;
#(
  parameter int ADDRW       = 32,
  parameter int DATAW       = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsel,
  input  logic [ADDRW-1:0] haddr,
  input  logic [1:0]       htrans,
  input  logic             hwrite,
  input  logic [2:0]       hsize,
  input  logic [2:0]       hburst,
  input  logic [3:0]       hprot,
  input  logic             hmastlock,
  input  logic [DATAW-1:0] hwdata,
  input  logic             hready_in,
  output logic             hready,
  output logic             hresp,
  output logic [DATAW-1:0] hrdata
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDRW-3:0] DEPTH_W = (ADDRW-2)'(MEM_DEPTH);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  ahb_s_state_e r_state, w_state_nxt;
  logic [3:0]    r_wait, w_wait_nxt;
  logic [AW-1:0] r_idx;
  logic [1:0]    r_lo;
  logic [2:0]    r_size;
  logic          r_write;

  logic             w_accept, w_legal, w_aligned, w_in_range, w_take, w_we;
  logic [DATAW-1:0] w_rdata;
  logic             w_unused_ign;

  assign w_unused_ign = &{1'b0, hburst, hprot, hmastlock};

  assign w_accept   = hsel & hready_in & htrans[1];
  assign w_in_range = haddr[ADDRW-1:2] < DEPTH_W;

  always_comb begin
    case (hsize)
      HSIZE_BYTE: w_aligned = 1'b1;
      HSIZE_HALF: w_aligned = ~haddr[0];
      HSIZE_WORD: w_aligned = (haddr[1:0] == 2'b00);
      default:    w_aligned = 1'b0;
    endcase
  end

  assign w_legal = w_aligned & w_in_range;
  assign w_take  = hready & w_accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_wait  <= '0;
      r_idx   <= '0;
      r_lo    <= '0;
      r_size  <= '0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      if (w_take) begin
        r_idx   <= haddr[AW+1:2];
        r_lo    <= haddr[1:0];
        r_size  <= hsize;
        r_write <= hwrite;
      end
    end
  end

  // Every hready=1 cycle (IDLE, ERR2, completing DATA) is an accept opportunity.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    if (hready) begin
      if (w_accept) begin
        w_state_nxt = w_legal ? ST_DATA : ST_ERR1;
        w_wait_nxt  = w_legal ? WAIT_LOAD : '0;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end else if (r_state == ST_ERR1) begin
      w_state_nxt = ST_ERR2;
    end else begin
      w_wait_nxt = r_wait - 4'd1;
    end
  end

  always_comb begin
    hready = 1'b1;
    hresp  = HRESP_OKAY;
    case (r_state)
      ST_IDLE: begin
        hready = 1'b1;
        hresp  = HRESP_OKAY;
      end
      ST_DATA: begin
        hready = (r_wait == 4'd0);
        hresp  = HRESP_OKAY;
      end
      ST_ERR1: begin
        hready = 1'b0;
        hresp  = HRESP_ERROR;
      end
      ST_ERR2: begin
        hready = 1'b1;
        hresp  = HRESP_ERROR;
      end
      default: begin
        hready = 1'b1;
        hresp  = HRESP_OKAY;
      end
    endcase
  end

  assign w_we   = (r_state == ST_DATA) && (r_wait == 4'd0) && r_write;
  assign hrdata = ((r_state == ST_DATA) && !r_write) ? w_rdata : '0;

  ahb_s_sram #(
    .MEM_DEPTH(MEM_DEPTH),
    .AW       (AW),
    .DW       (DATAW)
  ) u_sram (
    .i_clk  (clk),
    .i_we   (w_we),
    .i_be   (lane_mask(r_lo, r_size)),
    .i_addr (r_idx),
    .i_wdata(hwdata),
    .o_rdata(w_rdata)
  );

endmodule

// File: tb/tb_ahb_s_mem.sv
// Bench for ahb_s_mem: one zero-wait and one two-wait instance share a bus, one
// active at a time, checked every cycle against a queue-of-cycles reference model.
module tb_ahb_s_mem;

  localparam int DEPTH = 256;
  localparam int WS0   = 0;
  localparam int WS1   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel;
  logic        hsel, hwrite, hmastlock;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;

  logic        hready0, hresp0, hready1, hresp1;
  logic [31:0] hrdata0, hrdata1;
  logic        bus_hready, bus_hresp;
  logic [31:0] bus_hrdata;

  always #5 clk = ~clk;

  assign bus_hready = sel ? hready1 : hready0;
  assign bus_hresp  = sel ? hresp1  : hresp0;
  assign bus_hrdata = sel ? hrdata1 : hrdata0;

  ahb_s_mem #(.ADDRW(32), .DATAW(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(WS0)) u_dut0 (
    .clk(clk), .rst(rst), .hsel(hsel & ~sel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
    .hmastlock(hmastlock), .hwdata(hwdata), .hready_in(bus_hready),
    .hready(hready0), .hresp(hresp0), .hrdata(hrdata0));

  ahb_s_mem #(.ADDRW(32), .DATAW(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(WS1)) u_dut1 (
    .clk(clk), .rst(rst), .hsel(hsel & sel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
    .hmastlock(hmastlock), .hwdata(hwdata), .hready_in(bus_hready),
    .hready(hready1), .hresp(hresp1), .hrdata(hrdata1));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one expected-output record per bus cycle.
  typedef struct {
    bit       rdy;
    bit       resp;
    bit       rd;
    bit       wr;
    int       d;
    int       widx;
    bit [3:0] be;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mm [2][DEPTH];
  bit   [3:0]  mk [2][DEPTH];

  task automatic enqueue(input int d, input int ws, input logic [31:0] a,
                         input logic [2:0] sz, input logic wr);
    int   nb;
    bit   legal;
    exp_t e;
    legal = (sz <= 3'd2);
    nb    = 1;
    if (legal) begin
      nb    = 1 << sz;
      legal = ((a % nb) == 0) && ((a / 4) < DEPTH);
    end
    if (!legal) begin
      q.push_back('{0, 1, 0, 0, d, 0, 4'h0});
      q.push_back('{1, 1, 0, 0, d, 0, 4'h0});
    end else begin
      e.rdy  = 0;
      e.resp = 0;
      e.rd   = !wr;
      e.wr   = wr;
      e.d    = d;
      e.widx = int'(a / 4);
      e.be   = 4'(((1 << nb) - 1) << (a % 4));
      for (int k = 0; k < ws; k++) q.push_back(e);
      e.rdy = 1;
      q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t        c;
    logic [31:0] m;
    c = '{1, 0, 0, 0, 0, 0, 4'h0};
    if (!rst) q.delete();
    else if (q.size() != 0) c = q.pop_front();
    chk("hready", 32'(bus_hready), 32'(c.rdy));
    chk("hresp", 32'(bus_hresp), 32'(c.resp));
    if (c.rd) begin
      m = {{8{mk[c.d][c.widx][3]}}, {8{mk[c.d][c.widx][2]}},
           {8{mk[c.d][c.widx][1]}}, {8{mk[c.d][c.widx][0]}}};
      chk("hrdata", bus_hrdata & m, mm[c.d][c.widx] & m);
    end else begin
      chk("hrdata_zero", bus_hrdata, 32'h0);
    end
    chk("other_ctl", sel ? {30'd0, hready0, hresp0} : {30'd0, hready1, hresp1}, 32'd2);
    chk("other_rdata", sel ? hrdata0 : hrdata1, 32'h0);
    if (rst) begin
      if (c.wr && c.rdy) begin
        for (int b = 0; b < 4; b++) begin
          if (c.be[b]) begin
            mm[c.d][c.widx][8*b +: 8] = hwdata[8*b +: 8];
            mk[c.d][c.widx][b]        = 1'b1;
          end
        end
      end
      if (c.rdy && hsel && htrans[1])
        enqueue(sel ? 1 : 0, sel ? WS1 : WS0, haddr, hsize, hwrite);
    end
  end

  // Stimulus: beat tables replayed by a pipelined master.
  bit          b_sel  [64];
  logic [1:0]  b_tr   [64];
  bit          b_wr   [64];
  logic [31:0] b_addr [64];
  logic [2:0]  b_size [64];
  logic [31:0] b_data [64];
  logic [31:0] cap_rd [64];
  bit          cap_resp [64];
  int          low_cnt;

  task automatic set_beat(input int i, input bit s, input logic [1:0] tr, input bit wr,
                          input logic [31:0] a, input logic [2:0] sz, input logic [31:0] dat);
    b_sel[i]  = s;
    b_tr[i]   = tr;
    b_wr[i]   = wr;
    b_addr[i] = a;
    b_size[i] = sz;
    b_data[i] = dat;
  endtask

  task automatic drive_beat(input int i);
    hsel   = b_sel[i];
    htrans = b_tr[i];
    hwrite = b_wr[i];
    haddr  = b_addr[i];
    hsize  = b_size[i];
  endtask

  task automatic drive_idle();
    hsel   = 1'b0;
    htrans = 2'd0;
    hwrite = 1'b0;
    haddr  = '0;
    hsize  = '0;
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_seq(input int n);
    int i;
    int guard;
    i       = 0;
    guard   = 0;
    low_cnt = 0;
    drive_beat(0);
    while (i <= n) begin
      @(negedge clk);
      if (bus_hready) begin
        if (i > 0) begin
          cap_rd[i-1]   = bus_hrdata;
          cap_resp[i-1] = bus_hresp;
        end
        @(posedge clk);
        #1;
        hwdata = (i < n) ? b_data[i] : '0;
        i++;
        if (i < n) drive_beat(i);
        else drive_idle();
      end else begin
        low_cnt++;
        @(posedge clk);
        #1;
      end
      guard++;
      if (guard > 500) begin
        tests++;
        fails++;
        $display("FAIL run_seq_timeout: got %0d beats expected %0d", i, n);
        drive_idle();
        i = n + 1;
      end
    end
  endtask

  task automatic single(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] dat);
    set_beat(0, 1, 2'd2, wr, a, sz, dat);
    run_seq(1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sel       = 1'b0;
    hwdata    = '0;
    hburst    = 3'd0;
    hprot     = 4'b0011;
    hmastlock = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl0", {30'd0, hready0, hresp0}, 32'd2);
    chk("reset_ctl1", {30'd0, hready1, hresp1}, 32'd2);
    chk("reset_rdata0", hrdata0, 32'h0);
    chk("reset_rdata1", hrdata1, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    single(1, 32'h10, 3'd2, 32'hDEADBEEF);
    chk("wr_zero_wait", 32'(low_cnt), 32'd0);
    single(0, 32'h10, 3'd2, 32'h0);
    chk("rd_deadbeef", cap_rd[0], 32'hDEADBEEF);
    chk("rd_zero_wait", 32'(low_cnt), 32'd0);

    single(1, 32'h20, 3'd2, 32'h0);
    single(1, 32'h21, 3'd0, 32'h0000AA00);
    single(1, 32'h22, 3'd1, 32'h55660000);
    single(0, 32'h20, 3'd2, 32'h0);
    chk("rd_lanes", cap_rd[0], 32'h5566AA00);

    single(1, 32'h402, 3'd2, 32'h11111111);
    chk("err_misal_resp", 32'(cap_resp[0]), 32'd1);
    chk("err_misal_low", 32'(low_cnt), 32'd1);
    single(1, 32'(DEPTH * 4), 3'd2, 32'h22222222);
    chk("err_range_resp", 32'(cap_resp[0]), 32'd1);
    single(1, 32'h10, 3'd3, 32'h33333333);
    chk("err_size_resp", 32'(cap_resp[0]), 32'd1);
    single(1, 32'h11, 3'd1, 32'hFFFFFFFF);
    chk("err_half_resp", 32'(cap_resp[0]), 32'd1);
    single(0, 32'h10, 3'd2, 32'h0);
    chk("err_mem_kept", cap_rd[0], 32'hDEADBEEF);

    set_beat(0, 1, 2'd2, 1, 32'h30, 3'd2, 32'h0BADF00D);
    set_beat(1, 1, 2'd2, 0, 32'h30, 3'd2, 32'h0);
    run_seq(2);
    chk("wr_rd_fwd0", cap_rd[1], 32'h0BADF00D);

    sel    = 1'b1;
    hburst = 3'd3;
    for (int k = 0; k < 4; k++)
      set_beat(k, 1, (k == 0) ? 2'd2 : 2'd3, 1, 32'h40 + 32'(4 * k), 3'd2, 32'(k + 1));
    run_seq(4);
    chk("burst_wr_low", 32'(low_cnt), 32'd8);
    for (int k = 0; k < 4; k++)
      set_beat(k, 1, (k == 0) ? 2'd2 : 2'd3, 0, 32'h40 + 32'(4 * k), 3'd2, 32'h0);
    run_seq(4);
    chk("burst_rd_low", 32'(low_cnt), 32'd8);
    for (int k = 0; k < 4; k++) chk("burst_rd", cap_rd[k], 32'(k + 1));
    hburst = 3'd0;

    set_beat(0, 1, 2'd2, 1, 32'h50, 3'd2, 32'hA5A55A5A);
    set_beat(1, 1, 2'd2, 0, 32'h50, 3'd2, 32'h0);
    run_seq(2);
    chk("wr_rd_fwd1", cap_rd[1], 32'hA5A55A5A);

    single(1, 32'h80, 3'd2, 32'hCAFEF00D);
    set_beat(0, 1, 2'd2, 1, 32'h80, 3'd2, 32'h1234);
    drive_beat(0);
    @(negedge clk);
    @(posedge clk);
    #1;
    hwdata = 32'h1234;
    drive_idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ctl", {30'd0, bus_hready, bus_hresp}, 32'd2);
    chk("midrst_rdata", bus_hrdata, 32'h0);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    hwdata = '0;
    single(0, 32'h80, 3'd2, 32'h0);
    chk("midrst_mem_kept", cap_rd[0], 32'hCAFEF00D);

    for (int d = 0; d < 2; d++) begin
      sel = (d == 1);
      for (int r = 0; r < 5; r++) begin
        for (int i = 0; i < 40; i++) begin
          int          p, widx;
          logic [2:0]  sz;
          logic [1:0]  tr, lo;
          p  = $urandom_range(0, 9);
          tr = (p < 1) ? 2'd0 : (p < 2) ? 2'd1 : (p < 6) ? 2'd2 : 2'd3;
          sz = ($urandom_range(0, 19) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
          widx = ($urandom_range(0, 19) == 0) ? int'($urandom_range(254, 258))
                                              : int'($urandom_range(0, 15));
          lo = 2'($urandom_range(0, 3));
          if (sz <= 3'd2 && $urandom_range(0, 9) != 0) lo = lo & ~2'((1 << sz) - 1);
          set_beat(i, ($urandom_range(0, 9) != 0), tr, 1'($urandom_range(0, 1)),
                   {32'(widx), 2'b00} | 32'(lo), sz, $urandom);
        end
        run_seq(40);
      end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
